// File: rtl/board_store_if.sv
// Bus bundle for board_store: init control, write/move ports, read port and status.
interface board_store_if #(
   parameter int ROWS = 4,
   parameter int COLS = 8,
   parameter int PW   = 5
);
   localparam int N  = ROWS * COLS;
   localparam int AW = $clog2(N);

   logic              init_start;
   logic              shuffle_en;
   logic [N*PW-1:0]   init_layout;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [PW-1:0]     wr_data;
   logic              mv_en;
   logic [AW-1:0]     mv_src;
   logic [AW-1:0]     mv_dst;
   logic [AW-1:0]     rd_addr;
   logic [PW-1:0]     rd_data;
   logic [N*PW-1:0]   board_flat;
   logic              busy;
   logic              done;
   logic              drop;

   modport master (
      output init_start, shuffle_en, init_layout,
      output wr_en, wr_addr, wr_data,
      output mv_en, mv_src, mv_dst,
      output rd_addr,
      input  rd_data, board_flat, busy, done, drop
   );

   modport slave (
      input  init_start, shuffle_en, init_layout,
      input  wr_en, wr_addr, wr_data,
      input  mv_en, mv_src, mv_dst,
      input  rd_addr,
      output rd_data, board_flat, busy, done, drop
   );
endinterface

// File: rtl/board_store.sv
// Game board register store: layout load, LFSR Fisher-Yates shuffle, write/move ports.
// state   | meaning
// IDLE    | board open for writes and moves
// LOAD    | copy init_layout into the board in one edge
// SHUFFLE | one swap attempt per edge, index counts down to 1
module board_store #(
   parameter int          ROWS = 4,
   parameter int          COLS = 8,
   parameter int          PW   = 5,
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic          CLK_50,
   input  logic          RESET,
   board_store_if.slave  bus
);
   localparam int          N         = ROWS * COLS;
   localparam int          AW        = $clog2(N);
   localparam logic [15:0] SEED_EFF  = (SEED == 16'h0) ? 16'hACE1 : SEED;
   localparam logic [15:0] LFSR_MASK = 16'hB400;
   localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHUFFLE} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   board [N];
   logic [N*PW-1:0] flat;
   logic [15:0]     lfsr, lfsr_nxt;
   logic [AW-1:0]   idx, j;
   logic            shuf_flag;
   logic            load_go, swap_go, mv_go, wr_go;
   logic            done_nxt, drop_nxt;
   logic            idle_ok, mv_addr_ok, wr_addr_ok;
   logic [PW-1:0]   rd_q;
   logic            done_q, drop_q;

   assign lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
   assign j        = lfsr[AW-1:0];

   always_ff @(posedge CLK_50 or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load_go   = 1'b0;
      swap_go   = 1'b0;
      done_nxt  = 1'b0;
      if (bus.init_start) begin
         state_nxt = LOAD;
      end else begin
         case (state)
            LOAD: begin
               load_go = 1'b1;
               if (shuf_flag) begin
                  state_nxt = SHUFFLE;
               end else begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end
            SHUFFLE: begin
               if (j <= idx) begin
                  swap_go = 1'b1;
                  if (idx == AW'(1)) begin
                     state_nxt = IDLE;
                     done_nxt  = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // A move always pre-empts a simultaneous write; anything not accepted is reported via drop.
   always_comb begin
      idle_ok    = (state == IDLE) && !bus.init_start;
      mv_addr_ok = (int'(bus.mv_src) < N) && (int'(bus.mv_dst) < N);
      wr_addr_ok = int'(bus.wr_addr) < N;
      mv_go      = bus.mv_en && idle_ok && mv_addr_ok && (bus.mv_src != bus.mv_dst);
      wr_go      = bus.wr_en && !bus.mv_en && idle_ok && wr_addr_ok;
      drop_nxt   = 1'b0;
      if (bus.mv_en && !(idle_ok && mv_addr_ok)) drop_nxt = 1'b1;
      if (bus.wr_en && !(idle_ok && wr_addr_ok && !bus.mv_en)) drop_nxt = 1'b1;
   end

   always_ff @(posedge CLK_50 or posedge RESET) begin
      if (RESET) begin
         lfsr      <= SEED_EFF;
         idx       <= LAST_IDX;
         shuf_flag <= 1'b0;
         done_q    <= 1'b0;
         drop_q    <= 1'b0;
         rd_q      <= '0;
      end else begin
         lfsr   <= lfsr_nxt;
         done_q <= done_nxt;
         drop_q <= drop_nxt;
         rd_q   <= (int'(bus.rd_addr) < N) ? board[bus.rd_addr] : '0;
         if (bus.init_start) begin
            idx       <= LAST_IDX;
            shuf_flag <= bus.shuffle_en;
         end else if (swap_go) begin
            idx <= idx - AW'(1);
         end
      end
   end

   always_ff @(posedge CLK_50 or posedge RESET) begin
      if (RESET) begin
         for (int k = 0; k < N; k++) board[k] <= '0;
      end else if (load_go) begin
         for (int k = 0; k < N; k++) board[k] <= bus.init_layout[k*PW +: PW];
      end else if (swap_go) begin
         board[idx] <= board[j];
         board[j]   <= board[idx];
      end else if (mv_go) begin
         board[bus.mv_dst] <= board[bus.mv_src];
         board[bus.mv_src] <= '0;
      end else if (wr_go) begin
         board[bus.wr_addr] <= bus.wr_data;
      end
   end

   always_comb begin
      flat = '0;
      for (int k = 0; k < N; k++) flat[k*PW +: PW] = board[k];
   end

   assign bus.board_flat = flat;
   assign bus.rd_data    = rd_q;
   assign bus.busy       = (state != IDLE);
   assign bus.done       = done_q;
   assign bus.drop       = drop_q;
endmodule
